snake_key_input: RTL and testbench

SNAKE_KEY_INPUT -- requirements
Module: snake_key_input

---
 rtl/snake_pkg.sv | 17 +
 rtl/snake_key_debounce.sv | 28 ++
 rtl/snake_key_input.sv | 56 +++++
 tb/tb_snake_key_input.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: direction encodings, key indices and the reversal helper shared by the key input block.
package snake_pkg;
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_ENTER = 4;
  localparam int NUM_KEYS  = 5;
  // Encodings are chosen so opposite headings differ only in bit 0.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction
endpackage

// File: rtl/snake_key_debounce.sv
// snake_key_debounce: 2-flop synchronizer plus counter debounce for one active-low key; level is active-high.
module snake_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 800000,
  parameter int CNT_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  logic [1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic pressed;
  assign pressed = ~sync[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (pressed == level) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= pressed;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/snake_key_input.sv
// snake_key_input: debounces five board keys, arbitrates direction presses into a heading and strobes enter.
// Define SNAKE_REVERSE_LOCK_EN to ignore presses that would reverse the snake.
module snake_key_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 800000,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       enter,
  output logic [1:0] dir,
  output logic       dir_chg,
  output logic       enter_pulse,
  output logic [4:0] key_level
);
`ifdef SNAKE_REVERSE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic [NUM_KEYS-1:0] raw, prev, press;
  logic [1:0] win;
  logic accept;
  assign raw = {enter, right, left, down, up};
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    snake_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(clk),
      .rst_n(rst_n),
      .raw(raw[k]),
      .level(key_level[k])
    );
  end
  // Priority picks the winner first; a locked-out winner is dropped, never replaced.
  always_comb begin
    press  = key_level & ~prev;
    win    = press[KEY_UP] ? DIR_UP : press[KEY_DOWN] ? DIR_DOWN : press[KEY_LEFT] ? DIR_LEFT : DIR_RIGHT;
    accept = (|press[KEY_RIGHT:KEY_UP]) && (win != dir) && !(LOCK && (win == opposite(dir)));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev        <= '0;
      dir         <= DIR_RIGHT;
      dir_chg     <= 1'b0;
      enter_pulse <= 1'b0;
    end else begin
      prev        <= key_level;
      dir         <= accept ? win : dir;
      dir_chg     <= accept;
      enter_pulse <= press[KEY_ENTER];
    end
endmodule

// File: tb/tb_snake_key_input.sv
// tb_snake_key_input: directed self-checking bench with DEBOUNCE_CYCLES = 4; expectations follow SNAKE_REVERSE_LOCK_EN.
module tb_snake_key_input;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1, enter = 1'b1;
  logic [1:0] dir;
  logic dir_chg, enter_pulse;
  logic [4:0] key_level;
  int n_cmp = 0;
  int n_err = 0;
`ifdef SNAKE_REVERSE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  snake_key_input #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .up(up), .down(down), .left(left), .right(right), .enter(enter),
    .dir(dir), .dir_chg(dir_chg), .enter_pulse(enter_pulse), .key_level(key_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic run_count(input int n, output int chg, output int ent);
    chg = 0;
    ent = 0;
    for (int i = 0; i < n; i++) begin
      step();
      chg += int'(dir_chg);
      ent += int'(enter_pulse);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({dir, dir_chg, enter_pulse, key_level} !== {2'b11, 1'b0, 1'b0, 5'b0}) begin
      n_err++;
      $display("FAIL reset_held: got %b want %b", {dir, dir_chg, enter_pulse, key_level}, 9'b110000000);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      n_cmp++;
      if ({dir, dir_chg, enter_pulse, key_level} !== {2'b11, 1'b0, 1'b0, 5'b0}) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: got %b want %b", i, {dir, dir_chg, enter_pulse, key_level}, 9'b110000000);
      end
    end
  endtask

  task automatic test_glitch();
    up = 1'b0;
    repeat (3) step();
    up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_cmp++;
      if (key_level !== 5'b0 || dir_chg !== 1'b0 || dir !== 2'b11) begin
        n_err++;
        $display("FAIL glitch cycle %0d: got lvl=%b chg=%b dir=%b want lvl=00000 chg=0 dir=11", i, key_level, dir_chg, dir);
      end
    end
  endtask

  task automatic test_hold();
    int chg, ent;
    up = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      n_cmp++;
      if (key_level[0] !== (i >= 6) || dir_chg !== (i == 7) || dir !== ((i >= 7) ? 2'b00 : 2'b11)) begin
        n_err++;
        $display("FAIL hold cycle %0d: got lvl0=%b chg=%b dir=%b want lvl0=%b chg=%b dir=%b",
                 i, key_level[0], dir_chg, dir, i >= 6, i == 7, (i >= 7) ? 2'b00 : 2'b11);
      end
    end
    up = 1'b1;
    run_count(10, chg, ent);
    n_cmp++;
    if (chg !== 0 || key_level !== 5'b0 || dir !== 2'b00) begin
      n_err++;
      $display("FAIL release: got chg=%0d lvl=%b dir=%b want chg=0 lvl=00000 dir=00", chg, key_level, dir);
    end
  endtask

  task automatic test_reverse();
    int chg, ent;
    down = 1'b0;
    run_count(12, chg, ent);
    down = 1'b1;
    n_cmp++;
    if (dir !== (LOCK ? 2'b00 : 2'b01) || chg !== (LOCK ? 0 : 1)) begin
      n_err++;
      $display("FAIL reverse: got dir=%b chg=%0d want dir=%b chg=%0d", dir, chg, LOCK ? 2'b00 : 2'b01, LOCK ? 0 : 1);
    end
    repeat (10) step();
    up = 1'b0;
    run_count(12, chg, ent);
    up = 1'b1;
    n_cmp++;
    if (dir !== 2'b00 || chg !== (LOCK ? 0 : 1)) begin
      n_err++;
      $display("FAIL same_or_back_up: got dir=%b chg=%0d want dir=00 chg=%0d", dir, chg, LOCK ? 0 : 1);
    end
    repeat (10) step();
  endtask

  task automatic test_priority();
    int chg, ent;
    left = 1'b0;
    right = 1'b0;
    run_count(12, chg, ent);
    left = 1'b1;
    right = 1'b1;
    n_cmp++;
    if (dir !== 2'b10 || chg !== 1) begin
      n_err++;
      $display("FAIL left_right: got dir=%b chg=%0d want dir=10 chg=1", dir, chg);
    end
    repeat (10) step();
    up = 1'b0;
    down = 1'b0;
    run_count(12, chg, ent);
    up = 1'b1;
    down = 1'b1;
    n_cmp++;
    if (dir !== 2'b00 || chg !== 1) begin
      n_err++;
      $display("FAIL up_down: got dir=%b chg=%0d want dir=00 chg=1", dir, chg);
    end
    repeat (10) step();
    down = 1'b0;
    left = 1'b0;
    run_count(12, chg, ent);
    down = 1'b1;
    left = 1'b1;
    n_cmp++;
    if (dir !== (LOCK ? 2'b00 : 2'b01) || chg !== (LOCK ? 0 : 1)) begin
      n_err++;
      $display("FAIL down_left: got dir=%b chg=%0d want dir=%b chg=%0d", dir, chg, LOCK ? 2'b00 : 2'b01, LOCK ? 0 : 1);
    end
    repeat (10) step();
  endtask

  task automatic test_enter();
    int chg, ent, tc, te;
    tc = 0;
    te = 0;
    for (int p = 0; p < 2; p++) begin
      enter = 1'b0;
      run_count(12, chg, ent);
      tc += chg;
      te += ent;
      n_cmp++;
      if (key_level !== 5'b10000) begin
        n_err++;
        $display("FAIL enter_level press %0d: got %b want 10000", p, key_level);
      end
      enter = 1'b1;
      run_count(10, chg, ent);
      tc += chg;
      te += ent;
    end
    n_cmp++;
    if (te !== 2 || tc !== 0) begin
      n_err++;
      $display("FAIL enter_pulses: got pulses=%0d chg=%0d want pulses=2 chg=0", te, tc);
    end
  endtask

  task automatic test_reset_mid();
    up = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dir, dir_chg, enter_pulse, key_level} !== {2'b11, 1'b0, 1'b0, 5'b0}) begin
      n_err++;
      $display("FAIL mid_reset: got %b want %b", {dir, dir_chg, enter_pulse, key_level}, 9'b110000000);
    end
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      n_cmp++;
      if (key_level[0] !== (i >= 6) || dir_chg !== (i == 7) || dir !== ((i >= 7) ? 2'b00 : 2'b11)) begin
        n_err++;
        $display("FAIL redebounce cycle %0d: got lvl0=%b chg=%b dir=%b want lvl0=%b chg=%b dir=%b",
                 i, key_level[0], dir_chg, dir, i >= 6, i == 7, (i >= 7) ? 2'b00 : 2'b11);
      end
    end
    up = 1'b1;
    repeat (10) step();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_hold();
    test_reverse();
    test_priority();
    test_enter();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
